// File: rtl/or16_rr_arbiter.sv
// or16_rr_arbiter: round-robin arbiter that shares one 16-bit bitwise-OR unit
// between NUM_REQ requesters. It has one registered result slot, which is
// tagged with the index of the winning requester.
// Optional feature macro: OR16_REDUCE_EN adds rsp_nz, which is the OR-reduce
// of the registered result.

// 16-bit bitwise OR datapath
module g_OR16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] out
);
    assign out = a | b;
endmodule

`ifdef OR16_REDUCE_EN
// 16-input OR reduction
module g_Or16Way (
    input  logic [15:0] in,
    output logic        out
);
    assign out = |in;
endmodule
`endif

module or16_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [16*NUM_REQ-1:0] req_a,
    input  logic [16*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [15:0]           rsp_data,
    output logic [ID_W-1:0]       rsp_id,
`ifdef OR16_REDUCE_EN
    output logic                  rsp_nz,
`endif
    output logic                  busy
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    buf_state_t          state;
    logic [ID_W-1:0]     rr_ptr;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic [ID_W-1:0]     cand;
    logic                found;
    logic                can_load;
    logic                accept;
    logic [15:0]         op_a [NUM_REQ];
    logic [15:0]         op_b [NUM_REQ];
    logic [15:0]         sel_a;
    logic [15:0]         sel_b;
    logic [15:0]         or_result;
    logic [ID_W-1:0]     next_ptr;

    // Split the packed operand buses into per-requester words
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op_a[g] = req_a[16*g +: 16];
        assign op_b[g] = req_b[16*g +: 16];
    end

    // Round-robin search: the first valid requester at or after rr_ptr, with wrap-around
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // One-hot operand select; with no grant it yields zeros (unused)
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sel_a = sel_a | (op_a[k] & {16{grant[k]}});
            sel_b = sel_b | (op_b[k] & {16{grant[k]}});
        end
    end

    g_OR16 u_or16 (
        .a   (sel_a),
        .b   (sel_b),
        .out (or_result)
    );

    assign can_load  = !rsp_valid || rsp_ready;
    assign req_ready = grant & {NUM_REQ{can_load && !reset}};
    assign accept    = |(req_valid & req_ready);
    assign next_ptr  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    assign rsp_valid = (state == FULL);
    assign busy      = rsp_valid || (|req_valid);

    // One-entry result buffer with the pointer update; an accept takes priority over draining
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= EMPTY;
            rsp_data <= '0;
            rsp_id   <= '0;
            rr_ptr   <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state    <= FULL;
                        rsp_data <= or_result;
                        rsp_id   <= grant_idx;
                        rr_ptr   <= next_ptr;
                    end
                end
                FULL: begin
                    if (accept) begin
                        rsp_data <= or_result;
                        rsp_id   <= grant_idx;
                        rr_ptr   <= next_ptr;
                    end else if (rsp_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef OR16_REDUCE_EN
    logic nz_next;

    g_Or16Way u_or16way (
        .in  (or_result),
        .out (nz_next)
    );

    // Non-zero flag follows the same load and hold rules as rsp_data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_nz <= 1'b0;
        end else if (accept) begin
            rsp_nz <= nz_next;
        end
    end
`endif

endmodule

// File: tb/tb_or16_rr_arbiter.sv
// Directed testbench for or16_rr_arbiter (NUM_REQ=4, ID_W=2).
// Inputs change 1 time unit after a rising edge. Outputs are sampled 1 time
// unit after the edge, or 1 time unit after an input change.
module tb_or16_rr_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_id;
    logic        busy;
`ifdef OR16_REDUCE_EN
    logic        rsp_nz;
`endif

    int passed = 0;
    int total  = 0;

    or16_rr_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
`ifdef OR16_REDUCE_EN
        .rsp_nz    (rsp_nz),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0) $display("FAIL rst_valid act=%b exp=0", rsp_valid); else passed++;
        total++; if (rsp_data !== 16'h0000) $display("FAIL rst_data act=%h exp=0000", rsp_data); else passed++;
        total++; if (rsp_id !== 2'd0) $display("FAIL rst_id act=%0d exp=0", rsp_id); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_busy act=%b exp=0", busy); else passed++;
        // load a result from requester 1 and hold it
        step();
        set_op(1, 16'h1200, 16'h0034);
        req_valid = 4'b0010;
        step();
        total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 16'h1234)
            $display("FAIL rst_load act=%b/%0d/%h exp=1/1/1234", rsp_valid, rsp_id, rsp_data); else passed++;
        req_valid = 4'b1111; rsp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0100) $display("FAIL rst_pre_grant act=%b exp=0100", req_ready); else passed++;
        // asynchronous reset in the middle of the cycle
        reset = 1'b1;
        #1;
        total++; if (rsp_valid !== 1'b0) $display("FAIL rst_async_valid act=%b exp=0", rsp_valid); else passed++;
        total++; if (req_ready !== 4'b0000) $display("FAIL rst_async_ready act=%b exp=0000", req_ready); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL rst_async_busy act=%b exp=1", busy); else passed++;
        step();
        reset = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0001) $display("FAIL rst_first_grant act=%b exp=0001", req_ready); else passed++;
        req_valid = 4'b0000;
        step(); step();
        total++; if (rsp_valid !== 1'b0) $display("FAIL rst_drain act=%b exp=0", rsp_valid); else passed++;
    endtask

    task automatic test_single();
        do_reset();
        rsp_ready = 1'b1;
        set_op(2, 16'h00F0, 16'h0F01);
        req_valid = 4'b0100;
        #1;
        total++; if (req_ready !== 4'b0100) $display("FAIL single_ready act=%b exp=0100", req_ready); else passed++;
        step();
        req_valid = 4'b0000;
        #1;
        total++; if (req_ready !== 4'b0000) $display("FAIL single_ready_off act=%b exp=0000", req_ready); else passed++;
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0FF1 || rsp_id !== 2'd2)
            $display("FAIL single_rsp act=%b/%h/%0d exp=1/0ff1/2", rsp_valid, rsp_data, rsp_id); else passed++;
        step();
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL single_drain act=%b/%b exp=0/0", rsp_valid, busy); else passed++;
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_id   [5];
        logic [15:0] exp_data [4];
        exp_id[0] = 2'd0; exp_id[1] = 2'd1; exp_id[2] = 2'd2; exp_id[3] = 2'd3; exp_id[4] = 2'd0;
        exp_data[0] = 16'h000F; exp_data[1] = 16'h00F1; exp_data[2] = 16'h0F02; exp_data[3] = 16'hF003;
        do_reset();
        set_op(0, 16'h0000, 16'h000F);
        set_op(1, 16'h0001, 16'h00F0);
        set_op(2, 16'h0002, 16'h0F00);
        set_op(3, 16'h0003, 16'hF000);
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        #1;
        for (int n = 0; n < 5; n++) begin
            total++; if (req_ready !== (4'b0001 << exp_id[n]))
                $display("FAIL rr_ready[%0d] act=%b exp=%b", n, req_ready, 4'b0001 << exp_id[n]); else passed++;
            step();
            total++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id[n] || rsp_data !== exp_data[exp_id[n]])
                $display("FAIL rr_rsp[%0d] act=%b/%0d/%h exp=1/%0d/%h", n, rsp_valid, rsp_id, rsp_data,
                         exp_id[n], exp_data[exp_id[n]]); else passed++;
        end
        req_valid = 4'b0000;
        step();
        total++; if (rsp_valid !== 1'b0) $display("FAIL rr_drain act=%b exp=0", rsp_valid); else passed++;
    endtask

    task automatic test_backpressure();
        // rr_ptr is 1 after the round-robin sequence
        set_op(1, 16'hAA00, 16'h00AA);
        set_op(0, 16'h5500, 16'h0055);
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        step();
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 16'hAAAA || rsp_id !== 2'd1)
            $display("FAIL bp_load act=%b/%h/%0d exp=1/aaaa/1", rsp_valid, rsp_data, rsp_id); else passed++;
        req_valid = 4'b0011;
        #1;
        total++; if (req_ready !== 4'b0000) $display("FAIL bp_ready act=%b exp=0000", req_ready); else passed++;
        step(); step();
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 16'hAAAA || rsp_id !== 2'd1)
            $display("FAIL bp_hold act=%b/%h/%0d exp=1/aaaa/1", rsp_valid, rsp_data, rsp_id); else passed++;
        total++; if (req_ready !== 4'b0000) $display("FAIL bp_ready_hold act=%b exp=0000", req_ready); else passed++;
        rsp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0001) $display("FAIL bp_release_ready act=%b exp=0001", req_ready); else passed++;
        step();
        req_valid = 4'b0000;
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h5555 || rsp_id !== 2'd0)
            $display("FAIL bp_b2b act=%b/%h/%0d exp=1/5555/0", rsp_valid, rsp_data, rsp_id); else passed++;
        step();
        total++; if (rsp_valid !== 1'b0) $display("FAIL bp_drain act=%b exp=0", rsp_valid); else passed++;
    endtask

    task automatic test_wrap_withdraw();
        // rr_ptr is 1 here
        set_op(3, 16'h3000, 16'h0003);
        set_op(0, 16'h0C00, 16'h00C0);
        rsp_ready = 1'b1;
        req_valid = 4'b1000;
        #1;
        total++; if (req_ready !== 4'b1000) $display("FAIL wr_grant3 act=%b exp=1000", req_ready); else passed++;
        step();
        total++; if (rsp_id !== 2'd3 || rsp_data !== 16'h3003)
            $display("FAIL wr_rsp3 act=%0d/%h exp=3/3003", rsp_id, rsp_data); else passed++;
        req_valid = 4'b1001;
        #1;
        total++; if (req_ready !== 4'b0001) $display("FAIL wr_wrap act=%b exp=0001", req_ready); else passed++;
        rsp_ready = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0000) $display("FAIL wr_stall act=%b exp=0000", req_ready); else passed++;
        step();
        req_valid = 4'b1000;
        step();
        total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3)
            $display("FAIL wr_held act=%b/%0d exp=1/3", rsp_valid, rsp_id); else passed++;
        rsp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b1000) $display("FAIL wr_withdraw act=%b exp=1000", req_ready); else passed++;
        req_valid = 4'b1001;
        #1;
        total++; if (req_ready !== 4'b0001) $display("FAIL wr_ptr_kept act=%b exp=0001", req_ready); else passed++;
        step();
        req_valid = 4'b0000;
        total++; if (rsp_id !== 2'd0 || rsp_data !== 16'h0CC0)
            $display("FAIL wr_rsp0 act=%0d/%h exp=0/0cc0", rsp_id, rsp_data); else passed++;
        step();
    endtask

    task automatic test_reduce();
`ifdef OR16_REDUCE_EN
        do_reset();
        total++; if (rsp_nz !== 1'b0) $display("FAIL nz_reset act=%b exp=0", rsp_nz); else passed++;
        rsp_ready = 1'b1;
        set_op(0, 16'h8000, 16'h0000);
        req_valid = 4'b0001;
        step();
        total++; if (rsp_nz !== 1'b1 || rsp_data !== 16'h8000)
            $display("FAIL nz_one act=%b/%h exp=1/8000", rsp_nz, rsp_data); else passed++;
        set_op(1, 16'h0000, 16'h0000);
        req_valid = 4'b0010;
        step();
        req_valid = 4'b0000;
        total++; if (rsp_nz !== 1'b0 || rsp_data !== 16'h0000 || rsp_id !== 2'd1)
            $display("FAIL nz_zero act=%b/%h/%0d exp=0/0000/1", rsp_nz, rsp_data, rsp_id); else passed++;
        step();
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap_withdraw();
        test_reduce();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
